// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states
// and the number of radix-2 iterations per operation.
package mdu_pkg;

    localparam int ITER_COUNT = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        FINISH = 2'b10
    } state_e;

endpackage

// File: rtl/mdu_core.sv
// Datapath: 64-bit accumulator with one shift-add / restoring shift-subtract
// step per cycle on operand magnitudes, plus the final sign fix-up.
module mdu_core
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  op_e             op,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    output logic [XLEN-1:0] res_hi,
    output logic [XLEN-1:0] res_lo
);

    logic [2*XLEN-1:0] acc_reg;
    logic [XLEN-1:0]   opnd_reg;
    logic              is_div_reg;
    logic              neg_main_reg;
    logic              neg_rem_reg;

    logic              signed_op;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     trial;
    logic [2*XLEN-1:0] step_next;
    logic [2*XLEN-1:0] prod;

    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        a_neg     = signed_op & in1[XLEN-1];
        b_neg     = signed_op & in2[XLEN-1];
        a_mag     = a_neg ? -in1 : in1;
        b_mag     = b_neg ? -in2 : in2;
    end

    // Multiply keeps the multiplier in the low half and shifts the product in from the top;
    // divide shifts the dividend out of the low half while quotient bits shift in.
    always_comb begin
        mul_sum = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
        trial   = acc_reg[2*XLEN-1:XLEN-1] - {1'b0, opnd_reg};
        if (!is_div_reg) begin
            step_next = {mul_sum, acc_reg[XLEN-1:1]};
        end else if (trial[XLEN]) begin
            step_next = {acc_reg[2*XLEN-2:0], 1'b0};
        end else begin
            step_next = {trial[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg      <= '0;
            opnd_reg     <= '0;
            is_div_reg   <= 1'b0;
            neg_main_reg <= 1'b0;
            neg_rem_reg  <= 1'b0;
        end else if (load) begin
            is_div_reg   <= op[1];
            acc_reg      <= {{XLEN{1'b0}}, (op[1] ? a_mag : b_mag)};
            opnd_reg     <= op[1] ? b_mag : a_mag;
            // A zero divisor leaves the all-ones quotient un-negated.
            neg_main_reg <= (a_neg ^ b_neg) && !(op[1] && (in2 == '0));
            neg_rem_reg  <= op[1] & a_neg;
        end else if (step) begin
            acc_reg <= step_next;
        end
    end

    always_comb begin
        prod = neg_main_reg ? -acc_reg : acc_reg;
        if (is_div_reg) begin
            res_lo = neg_main_reg ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
            res_hi = neg_rem_reg ? -acc_reg[2*XLEN-1:XLEN] : acc_reg[2*XLEN-1:XLEN];
        end else begin
            res_lo = prod[XLEN-1:0];
            res_hi = prod[2*XLEN-1:XLEN];
        end
    end

endmodule

// File: rtl/mdu_unit.sv
// Iterative multiply/divide unit with HI/LO registers: FSM, iteration counter,
// MTHI/MTLO writes and the busy/done handshake. Only XLEN=32 is supported.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic            hi_we,
    input  logic            lo_we,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            busy,
    output logic            done
);

    state_e          state_reg, state_next;
    logic [4:0]      count_reg, count_next;
    logic [XLEN-1:0] hi_reg, hi_next;
    logic [XLEN-1:0] lo_reg, lo_next;
    logic            done_reg, done_next;
    logic            load;
    logic            step;
    logic [XLEN-1:0] res_hi;
    logic [XLEN-1:0] res_lo;

    mdu_core #(.XLEN(XLEN)) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .step   (step),
        .op     (op_e'(op)),
        .in1    (in1),
        .in2    (in2),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            count_reg <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        done_next  = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    count_next = 5'(ITER_COUNT - 1);
                    state_next = RUN;
                end else begin
                    if (hi_we) hi_next = in1;
                    if (lo_we) lo_next = in1;
                end
            end
            RUN: begin
                step       = 1'b1;
                count_next = count_reg - 5'd1;
                if (count_reg == 5'd0) state_next = FINISH;
            end
            FINISH: begin
                hi_next    = res_hi;
                lo_next    = res_lo;
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state_reg != IDLE);
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: stimulus pushes expected HI/LO from an
// arithmetic reference model; a negedge monitor pops and compares on done.
module tb_mdu_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] in1 = '0;
    logic [31:0] in2 = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;
    int          busy_run = 0;

    mdu_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .in1   (in1),
        .in2   (in2),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV division truncates toward zero.
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: p = {32'b0, a} * {32'b0, b};
            2'b01: p = 64'(sa * sb);
            2'b10: p = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: begin
                if (b == 0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
        endcase
        return p;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst_n) begin
            busy_run = 0;
        end else if (busy) begin
            busy_run++;
        end else begin
            if (done) begin
                check("busy_len", 32'(busy_run), 32'd33);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=done required=no_done");
                end else begin
                    e = exp_q.pop_front();
                    check("hi", hi, e[63:32]);
                    check("lo", lo, e[31:0]);
                end
            end
            busy_run = 0;
        end
    end

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit with_we);
        logic [63:0] e;
        logic [31:0] old_hi, old_lo;
        bit          seen;
        old_hi = model_hi;
        old_lo = model_lo;
        op     = o;
        in1    = a;
        in2    = b;
        start  = 1'b1;
        hi_we  = with_we;
        lo_we  = with_we;
        e = ref_model(o, a, b);
        exp_q.push_back(e);
        model_hi = e[63:32];
        model_lo = e[31:0];
        $display("OP op=%0d in1=%h in2=%h we=%0d expect hi=%h lo=%h", o, a, b, with_we,
                 e[63:32], e[31:0]);
        seen = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (i == 1 && with_we) begin
                check("start_wins_hi", hi, old_hi);
                check("start_wins_lo", lo, old_lo);
            end
            if (done) begin
                seen = 1;
            end else if (i == 5) begin
                start = 1'b1;
                op    = 2'b10;
                in1   = 32'd9;
                in2   = 32'd3;
                hi_we = 1'b1;
                lo_we = 1'b0;
            end else if (i <= 30) begin
                start = 1'($urandom_range(0, 1));
                op    = 2'($urandom_range(0, 3));
                in1   = $urandom;
                in2   = $urandom;
                hi_we = 1'($urandom_range(0, 1));
                lo_we = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
                hi_we = 1'b0;
                lo_we = 1'b0;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=no_done required=done");
        end
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
    endtask

    initial begin
        #1;
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(2'b01, 32'hFFFF_FFFD, 32'd7, 0);
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(2'b10, 32'd7, 32'd0, 0);
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(2'b11, 32'hFFFF_FFF9, 32'd0, 0);
        run_op(2'b00, 32'd2, 32'd3, 0);

        @(negedge clk);
        hi_we = 1'b1;
        in1   = 32'h1234_5678;
        @(negedge clk);
        hi_we = 1'b0;
        $display("MTHI in1=12345678");
        check("mthi_hi", hi, 32'h1234_5678);
        check("mthi_lo", lo, model_lo);
        model_hi = 32'h1234_5678;
        hi_we = 1'b1;
        lo_we = 1'b1;
        in1   = 32'hCAFE_F00D;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        $display("MTHI+MTLO in1=cafef00d");
        check("mthilo_hi", hi, 32'hCAFE_F00D);
        check("mthilo_lo", lo, 32'hCAFE_F00D);
        model_hi = 32'hCAFE_F00D;
        model_lo = 32'hCAFE_F00D;

        run_op(2'b11, 32'h0000_0064, 32'hFFFF_FFF9, 1);

        op    = 2'b00;
        in1   = 32'd7;
        in2   = 32'd9;
        start = 1'b1;
        $display("OP op=0 in1=00000007 in2=00000009 aborted by reset");
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        check("abort_done", 32'(done), 32'h0);
        model_hi = '0;
        model_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        run_op(2'b00, 32'd5, 32'd5, 0);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a, b;
            logic [1:0]  o;
            a = pick();
            b = pick();
            o = 2'($urandom_range(0, 3));
            run_op(o, a, b, bit'($urandom_range(0, 3) == 0));
        end

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
